// File: rtl/csa_ks_packer.sv
// csa_ks_packer: drops init slices, packs 2-bit keystream slices MSB-first into bytes, buffers them in a 2-entry FIFO
module csa_ks_packer #(
  parameter int INIT_ROUNDS = 32,
  parameter int NBYTES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] ks_in,
  input  logic       ks_valid,
  output logic       ks_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       busy,
  output logic       done
);
  localparam int IW = INIT_ROUNDS > 0 ? $clog2(INIT_ROUNDS + 1) : 1;
  localparam int BW = $clog2(NBYTES + 1);
  localparam logic [IW-1:0] ILAST = IW'(INIT_ROUNDS > 0 ? INIT_ROUNDS - 1 : 0);
  localparam logic [BW-1:0] BLAST = BW'(NBYTES - 1);
  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] icnt;
  logic [BW-1:0] bcnt;
  logic [1:0] scnt, cnt;
  logic [7:0] sreg;
  logic [7:0] mem [2];
  logic wp, rp, acc, push, pop;
  assign ks_ready = state == INIT || (state == RUN && cnt != 2'd2);
  assign acc = ks_valid && ks_ready;
  assign push = state == RUN && acc && scnt == 2'd3;
  assign byte_valid = cnt != 2'd0;
  assign pop = byte_valid && byte_ready;
  assign byte_out = mem[rp];
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? (INIT_ROUNDS > 0 ? INIT : RUN) : IDLE;
      INIT:    state_n = acc && icnt == ILAST ? RUN : INIT;
      RUN:     state_n = push && bcnt == BLAST ? DRAIN : RUN;
      DRAIN:   state_n = cnt == 2'd0 ? DONE : DRAIN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      icnt <= '0;
      bcnt <= '0;
      scnt <= '0;
      sreg <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        icnt <= '0;
        bcnt <= '0;
        scnt <= '0;
      end
      if (state == INIT && acc) icnt <= icnt + 1'b1;
      if (state == RUN && acc) begin
        sreg[{~scnt, 1'b0} +: 2] <= ks_in;
        scnt <= scnt + 1'b1;
      end
      if (push) begin
        mem[wp] <= {sreg[7:2], ks_in};
        wp <= ~wp;
        bcnt <= bcnt + 1'b1;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_csa_ks_packer.sv
// tb_csa_ks_packer: directed self-checking bench for csa_ks_packer
module tb_csa_ks_packer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic sa, kva, kra, bva, bra, busya, donea;
  logic sb, kvb, krb, bvb, brb, busyb, doneb;
  logic [1:0] ka, kb;
  logic [7:0] boa, bob;
  int checks = 0;
  int fails = 0;
  int nda = 0;
  int ndb = 0;
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  csa_ks_packer #(.INIT_ROUNDS(2), .NBYTES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(sa), .ks_in(ka), .ks_valid(kva), .ks_ready(kra),
    .byte_out(boa), .byte_valid(bva), .byte_ready(bra), .busy(busya), .done(donea)
  );
  csa_ks_packer #(.INIT_ROUNDS(0), .NBYTES(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(sb), .ks_in(kb), .ks_valid(kvb), .ks_ready(krb),
    .byte_out(bob), .byte_valid(bvb), .byte_ready(brb), .busy(busyb), .done(doneb)
  );
  always @(posedge clk) begin
    if (rst_n && bva && bra) qa.push_back(boa);
    if (rst_n && bvb && brb) qb.push_back(bob);
    if (donea) nda <= nda + 1;
    if (doneb) ndb <= ndb + 1;
  end
  task automatic feed_a(input logic [1:0] s, input logic st);
    ka = s;
    kva = 1'b1;
    sa = st;
    @(negedge clk);
    kva = 1'b0;
    sa = 1'b0;
  endtask
  task automatic feed_b(input logic [1:0] s);
    kb = s;
    kvb = 1'b1;
    @(negedge clk);
    kvb = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    {sa, kva, bra, sb, kvb, brb} = '0;
    ka = 2'd0;
    kb = 2'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({kra, boa, bva, busya, donea} !== 12'h0) begin
      fails++;
      $display("FAIL reset_a: got %h want 000", {kra, boa, bva, busya, donea});
    end
    checks++;
    if ({krb, bob, bvb, busyb, doneb} !== 12'h0) begin
      fails++;
      $display("FAIL reset_b: got %h want 000", {krb, bob, bvb, busyb, doneb});
    end
    rst_n = 1'b1;
    kva = 1'b1;
    kvb = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({kra, busya, krb, busyb} !== 4'h0) begin
        fails++;
        $display("FAIL idle_no_accept: got %b want 0000", {kra, busya, krb, busyb});
      end
    end
    kva = 1'b0;
    kvb = 1'b0;
  endtask
  task automatic test_basic;
    logic [1:0] sl [10];
    int q0, d0, n;
    sl = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    q0 = qa.size();
    d0 = nda;
    bra = 1'b1;
    sa = 1'b1;
    @(negedge clk);
    sa = 1'b0;
    checks++;
    if ({busya, kra} !== 2'b11) begin
      fails++;
      $display("FAIL basic_start: busy/ks_ready got %b want 11", {busya, kra});
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (kra !== 1'b1) begin
        fails++;
        $display("FAIL basic_ready slice %0d: got %b want 1", i, kra);
      end
      feed_a(sl[i], 1'b0);
      if (i == 5) begin
        checks++;
        if ({bva, boa} !== {1'b1, 8'h93}) begin
          fails++;
          $display("FAIL basic_latency: got %b/%h want 1/93", bva, boa);
        end
      end
    end
    checks++;
    if (kra !== 1'b0) begin
      fails++;
      $display("FAIL basic_drain_ready: got %b want 0", kra);
    end
    n = 0;
    while (donea !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 2) begin
      fails++;
      $display("FAIL basic_done_timing: cycles %0d want 2", n);
    end
    @(negedge clk);
    checks++;
    if ({donea, busya} !== 2'b00) begin
      fails++;
      $display("FAIL basic_idle: done/busy got %b want 00", {donea, busya});
    end
    checks++;
    if (qa.size() - q0 !== 2 || qa[q0] !== 8'h93 || qa[q0+1] !== 8'h1B) begin
      fails++;
      $display("FAIL basic_bytes: count %0d first %h second %h want 2 93 1b", qa.size() - q0, qa[q0], qa[q0+1]);
    end
    checks++;
    if (nda - d0 !== 1) begin
      fails++;
      $display("FAIL basic_done_pulses: got %0d want 1", nda - d0);
    end
  endtask
  task automatic test_backpressure;
    logic [1:0] sl [16];
    logic [7:0] ex [4];
    logic r;
    int idx, q0, d0, n;
    sl = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd3, 2'd3, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3};
    ex = '{8'hA5, 8'h3C, 8'hF0, 8'h0F};
    idx = 0;
    q0 = qb.size();
    d0 = ndb;
    brb = 1'b0;
    sb = 1'b1;
    @(negedge clk);
    sb = 1'b0;
    repeat (12) begin
      kb = sl[idx];
      kvb = 1'b1;
      r = krb;
      @(negedge clk);
      if (r) idx++;
    end
    checks++;
    if (idx !== 8 || krb !== 1'b0) begin
      fails++;
      $display("FAIL bp_stall: accepted %0d ks_ready %b want 8 0", idx, krb);
    end
    checks++;
    if ({bvb, bob} !== {1'b1, 8'hA5}) begin
      fails++;
      $display("FAIL bp_head: got %b/%h want 1/a5", bvb, bob);
    end
    brb = 1'b1;
    kb = sl[idx];
    @(negedge clk);
    checks++;
    if (krb !== 1'b1 || qb.size() - q0 !== 1) begin
      fails++;
      $display("FAIL bp_resume: ks_ready %b pops %0d want 1 1", krb, qb.size() - q0);
    end
    n = 0;
    while (idx < 16 && n < 40) begin
      kb = sl[idx];
      kvb = 1'b1;
      r = krb;
      @(negedge clk);
      if (r) idx++;
      n++;
    end
    kvb = 1'b0;
    n = 0;
    while (doneb !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      fails++;
      $display("FAIL bp_done_timeout: waited %0d cycles want done", n);
    end
    @(negedge clk);
    checks++;
    if (qb.size() - q0 !== 4) begin
      fails++;
      $display("FAIL bp_count: got %0d want 4", qb.size() - q0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (qb[q0+i] !== ex[i]) begin
        fails++;
        $display("FAIL bp_byte %0d: got %h want %h", i, qb[q0+i], ex[i]);
      end
    end
    checks++;
    if (ndb - d0 !== 1 || busyb !== 1'b0) begin
      fails++;
      $display("FAIL bp_done: pulses %0d busy %b want 1 0", ndb - d0, busyb);
    end
  endtask
  task automatic test_push_pop;
    logic [7:0] ex [4];
    int q0, d0, n;
    ex = '{8'h1E, 8'hB4, 8'h69, 8'hC3};
    q0 = qb.size();
    d0 = ndb;
    brb = 1'b0;
    sb = 1'b1;
    @(negedge clk);
    sb = 1'b0;
    feed_b(2'd0);
    feed_b(2'd1);
    feed_b(2'd3);
    feed_b(2'd2);
    checks++;
    if ({bvb, bob} !== {1'b1, 8'h1E}) begin
      fails++;
      $display("FAIL pp_first: got %b/%h want 1/1e", bvb, bob);
    end
    feed_b(2'd2);
    feed_b(2'd3);
    feed_b(2'd1);
    kb = 2'd0;
    kvb = 1'b1;
    brb = 1'b1;
    @(negedge clk);
    kvb = 1'b0;
    brb = 1'b0;
    checks++;
    if ({bvb, bob, krb} !== {1'b1, 8'hB4, 1'b1} || qb.size() - q0 !== 1) begin
      fails++;
      $display("FAIL pp_same_cycle: valid %b head %h ready %b pops %0d want 1 b4 1 1", bvb, bob, krb, qb.size() - q0);
    end
    brb = 1'b1;
    feed_b(2'd1);
    feed_b(2'd2);
    feed_b(2'd2);
    feed_b(2'd1);
    feed_b(2'd3);
    feed_b(2'd0);
    feed_b(2'd0);
    feed_b(2'd3);
    n = 0;
    while (doneb !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      fails++;
      $display("FAIL pp_done_timeout: waited %0d cycles want done", n);
    end
    @(negedge clk);
    checks++;
    if (qb.size() - q0 !== 4 || ndb - d0 !== 1) begin
      fails++;
      $display("FAIL pp_count: bytes %0d dones %0d want 4 1", qb.size() - q0, ndb - d0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (qb[q0+i] !== ex[i]) begin
        fails++;
        $display("FAIL pp_byte %0d: got %h want %h", i, qb[q0+i], ex[i]);
      end
    end
  endtask
  task automatic test_reset_midrun;
    int q0, n;
    bra = 1'b1;
    sa = 1'b1;
    @(negedge clk);
    sa = 1'b0;
    feed_a(2'd3, 1'b0);
    feed_a(2'd3, 1'b0);
    feed_a(2'd2, 1'b0);
    feed_a(2'd1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({busya, bva, kra, donea, boa} !== 12'h0) begin
      fails++;
      $display("FAIL mid_reset: got %h want 000", {busya, bva, kra, donea, boa});
    end
    q0 = qa.size();
    sa = 1'b1;
    @(negedge clk);
    sa = 1'b0;
    feed_a(2'd0, 1'b0);
    feed_a(2'd0, 1'b0);
    repeat (4) feed_a(2'd1, 1'b0);
    checks++;
    if ({bva, boa} !== {1'b1, 8'h55}) begin
      fails++;
      $display("FAIL mid_first_byte: got %b/%h want 1/55", bva, boa);
    end
    repeat (4) feed_a(2'd1, 1'b0);
    n = 0;
    while (donea !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (n >= 20 || qa.size() - q0 !== 2 || qa[q0] !== 8'h55 || qa[q0+1] !== 8'h55) begin
      fails++;
      $display("FAIL mid_bytes: wait %0d count %0d bytes %h %h want <20 2 55 55", n, qa.size() - q0, qa[q0], qa[q0+1]);
    end
  endtask
  task automatic test_start_ignored;
    int q0, d0, n;
    q0 = qa.size();
    d0 = nda;
    bra = 1'b1;
    sa = 1'b1;
    @(negedge clk);
    sa = 1'b0;
    feed_a(2'd0, 1'b0);
    feed_a(2'd0, 1'b0);
    feed_a(2'd3, 1'b1);
    feed_a(2'd0, 1'b0);
    feed_a(2'd3, 1'b0);
    feed_a(2'd0, 1'b0);
    feed_a(2'd0, 1'b0);
    feed_a(2'd3, 1'b0);
    feed_a(2'd0, 1'b0);
    feed_a(2'd3, 1'b0);
    sa = 1'b1;
    @(negedge clk);
    sa = 1'b0;
    n = 0;
    while (donea !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      fails++;
      $display("FAIL si_done_timeout: waited %0d cycles want done", n);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({busya, donea} !== 2'b00) begin
        fails++;
        $display("FAIL si_stays_idle: busy/done got %b want 00", {busya, donea});
      end
    end
    checks++;
    if (qa.size() - q0 !== 2 || qa[q0] !== 8'hCC || qa[q0+1] !== 8'h33 || nda - d0 !== 1) begin
      fails++;
      $display("FAIL si_bytes: count %0d bytes %h %h dones %0d want 2 cc 33 1", qa.size() - q0, qa[q0], qa[q0+1], nda - d0);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_push_pop();
    test_reset_midrun();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/csa_ks_packer.md
# csa_ks_packer

Keystream packer that sits directly downstream of the CSA stream-cipher round, which combines its seven sbox outputs into one 2-bit keystream slice per round. The block discards the initialisation rounds, packs four consecutive 2-bit slices into one keystream byte MSB-first, and buffers bytes in a 2-entry FIFO toward the block-cipher/XOR stage. It back-pressures the cipher round when the FIFO cannot accept a byte, and signals completion after a fixed number of bytes.

## Interface
- INIT_ROUNDS, 32, number of leading slices discarded after start; 0 is legal.
- NBYTES, 8, bytes produced per start; must be at least 1.
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  one-cycle request to begin a keystream run; honoured only in IDLE.
- ks_in  in  2  keystream slice from the cipher round.
- ks_valid  in  1  ks_in is valid this cycle.
- ks_ready  out  1  packer accepts ks_in this cycle; a slice transfers when ks_valid and ks_ready are both 1.
- byte_out  out  8  keystream byte at the FIFO head.
- byte_valid  out  1  byte_out is valid; FIFO is not empty.
- byte_ready  in  1  consumer takes byte_out; a pop happens when byte_valid and byte_ready are both 1.
- busy  out  1  1 in every state except IDLE.
- done  out  1  one-cycle pulse when the run completes.

## Operation
- States:
  - IDLE: start moves to INIT when INIT_ROUNDS>0, otherwise to RUN.
  - INIT: discards slices; ks_ready=1. After the INIT_ROUNDS-th accepted slice, moves to RUN.
  - RUN: packs slices; ks_ready = (fifo_count<2).
  - DRAIN: ks_ready=0; waits for the FIFO to empty.
  - DONE: asserts done for one cycle, then returns to IDLE.
- Discard counter width is clog2(INIT_ROUNDS+1). It is cleared on start and increments per accepted slice in INIT.
- Packing:
  - Slice counter (2 bits) selects the destination: slice 0 goes to sreg[7:6], slice 1 to [5:4], slice 2 to [3:2], slice 3 to [1:0].
  - On slice 3, the byte {sreg[7:2], ks_in} is pushed into the FIFO in the same cycle and the slice counter wraps to 0.
- Byte counter width is clog2(NBYTES+1) and counts pushes. When the NBYTES-th push occurs, the state moves RUN→DRAIN.
- FIFO:
  - 2 entries, count 0..2.
  - A push and a pop in the same cycle leave the count unchanged.
  - A push is only possible when count<2, which ks_ready guarantees.
  - A pop when empty is ignored.
- DRAIN→DONE happens in the cycle after the FIFO count reaches 0.
- start outside IDLE is ignored. Slices offered in IDLE, DRAIN or DONE are not accepted (ks_ready=0).
- Reset (rst_n=0 at an edge) applies in any state, including mid-run:
  - state returns to IDLE;
  - all counters, sreg and the FIFO are cleared;
  - a partially packed byte is lost.
- Reset values of outputs: ks_ready=0, byte_out=8'h00, byte_valid=0, busy=0, done=0.

## Timing
- start sampled at edge t: busy=1 and ks_ready=1 from t+1.
- Slice 3 accepted at edge t with the FIFO empty: byte_valid=1 and byte_out valid from t+1 (1-cycle latency).
- FIFO output is registered; byte_out and byte_valid do not depend combinationally on byte_ready.
- ks_ready is combinational from state and fifo_count only; it never depends on ks_valid.
- Throughput: one slice per cycle and one byte per 4 cycles when byte_ready=1 continuously; no bubbles.
- The last pop at edge t gives count 0 from t+1; DONE is entered at t+2 and done=1 during t+2..t+3; IDLE is entered at t+3 with busy=0.
- A run with INIT_ROUNDS=32, NBYTES=8, no stalls and byte_ready=1 takes 64 accepted slices (32 discarded + 32 packed) before DRAIN.

## Test plan
- Reset/idle: rst_n=0 for 2 cycles → all outputs 0. With start=0, slices offered with ks_valid=1 are never accepted.
- Basic pack (INIT_ROUNDS=2, NBYTES=2): slices 3,3 (discarded), then 2,1,0,3, 0,1,2,3 → bytes 8'h93 then 8'h1B; then done=1 for one cycle and busy=0.
- Back-pressure (INIT_ROUNDS=0, NBYTES=4): byte_ready=0 and ks_valid=1 continuously → ks_ready drops after 8 slices (FIFO count 2). Raising byte_ready pops one byte per cycle and packing resumes. All 4 bytes arrive in order and none are lost or duplicated.
- Simultaneous push and pop: FIFO at count 1, 4th slice accepted in the same cycle as a pop → count stays 1 and byte order is preserved.
- Reset mid-run: rst_n=0 after 2 slices of byte 1 → IDLE with byte_valid=0. A new start with slices 1,1,1,1 → first byte is 8'h55; no stale bits.
- start ignored while busy: a second start in RUN and one in DRAIN → exactly NBYTES bytes and a single done pulse.
